hex_display_ctrl: RTL

Registered, parametrised multi-digit driver for the DE1 seven-segment displays. It takes a binary value with a load strobe, then converts it to hex nibbles or to decimal BCD using a sequential shift-add-3 engine. It also applies leading-zero blanking, an overflow dash pattern and a free-running blink. It replaces per-switch combinational decoding wherever a counter or datapath result must be shown on HEX0..HEX(DIGITS-1).

---
 rtl/seg7_pkg.sv | 65 ++++++
 rtl/seg7_glyph.sv | 11 +
 rtl/hex_display_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph table, FSM states and helpers
// for the hex/decimal display controller.
package seg7_pkg;

  localparam logic [6:0] G_0 = 7'b0000001;
  localparam logic [6:0] G_1 = 7'b1001111;
  localparam logic [6:0] G_2 = 7'b0010010;
  localparam logic [6:0] G_3 = 7'b0000110;
  localparam logic [6:0] G_4 = 7'b1001100;
  localparam logic [6:0] G_5 = 7'b0100100;
  localparam logic [6:0] G_6 = 7'b0100000;
  localparam logic [6:0] G_7 = 7'b0001111;
  localparam logic [6:0] G_8 = 7'b0000000;
  localparam logic [6:0] G_9 = 7'b0000100;
  localparam logic [6:0] G_A = 7'b0001000;
  localparam logic [6:0] G_B = 7'b1100000;
  localparam logic [6:0] G_C = 7'b0110001;
  localparam logic [6:0] G_D = 7'b1000010;
  localparam logic [6:0] G_E = 7'b0110000;
  localparam logic [6:0] G_F = 7'b0111000;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH = 7'b1111110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_t;

  function automatic logic [6:0] glyph(
    input logic [3:0] nibble
  );
    logic [6:0] g;
    unique case (nibble)
      4'h0: g = G_0;
      4'h1: g = G_1;
      4'h2: g = G_2;
      4'h3: g = G_3;
      4'h4: g = G_4;
      4'h5: g = G_5;
      4'h6: g = G_6;
      4'h7: g = G_7;
      4'h8: g = G_8;
      4'h9: g = G_9;
      4'hA: g = G_A;
      4'hB: g = G_B;
      4'hC: g = G_C;
      4'hD: g = G_D;
      4'hE: g = G_E;
      4'hF: g = G_F;
    endcase
    return g;
  endfunction

  function automatic logic [63:0] pow10(
    input int n
  );
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++)
      p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble to active-low a..g glyph.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = glyph(nibble);

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment driver: hex or double-dabble BCD,
// leading-zero blanking, overflow dashes and blink.
module hex_display_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WIDTH = 14,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  input  logic                  dec_mode,
  input  logic                  lz_blank,
  input  logic                  blink_en,
  output logic                  busy,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int NB = 4 * DIGITS;
  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam logic [5:0] LAST = 6'(WIDTH - 1);
  localparam logic [31:0] BL_MAX = 32'(BLINK_HALF - 1);

  state_t state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic dm_q, dm_d;
  logic lz_q, lz_d;
  logic ovp_q, ovp_d;
  logic [5:0] cnt_q, cnt_d;
  logic [NB-1:0] bcd_q, bcd_d;
  logic [NB-1:0] dig_q, dig_d;
  logic [NB-1:0] adj;
  logic [NB-1:0] hex_bits;
  logic ovf_q, ovf_d;
  logic lzc_q, lzc_d;
  logic ld_q, ld_d;
  logic busy_q, busy_d;
  logic [31:0] bcnt_q, bcnt_d;
  logic ph_q, ph_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic ovf_hex, ovf_dec;
  logic [6:0] gl [DIGITS];

  if (WIDTH > NB) begin : g_wide
    assign ovf_hex = |value[WIDTH-1:NB];
    assign hex_bits = val_q[NB-1:0];
  end else begin : g_narrow
    assign ovf_hex = 1'b0;
    assign hex_bits = NB'(val_q);
  end

  assign ovf_dec = 64'(value) >= LIMIT;

  for (genvar i = 0; i < DIGITS; i++) begin : g_gl
    seg7_glyph u_gl (
      .nibble (dig_q[4*i +: 4]),
      .seg    (gl[i])
    );
  end

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5)
                    ? bcd_q[4*i +: 4] + 4'd3
                    : bcd_q[4*i +: 4];
  end

  always_comb begin
    state_d = state_q;
    val_d = val_q;
    dm_d = dm_q;
    lz_d = lz_q;
    ovp_d = ovp_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    dig_d = dig_q;
    ovf_d = ovf_q;
    lzc_d = lzc_q;
    ld_d = ld_q;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          val_d = value;
          dm_d = dec_mode;
          lz_d = lz_blank;
          ovp_d = dec_mode ? ovf_dec : ovf_hex;
          cnt_d = LAST;
          bcd_d = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (!dm_q) begin
          bcd_d = hex_bits;
          state_d = S_COMMIT;
        end else begin
          bcd_d = {adj[NB-2:0], val_q[WIDTH-1]};
          val_d = val_q << 1;
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd0)
            state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        dig_d = bcd_q;
        ovf_d = ovp_q;
        lzc_d = lz_q;
        ld_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    bcnt_d = bcnt_q + 32'd1;
    ph_d = ph_q;
    if (bcnt_q >= BL_MAX) begin
      bcnt_d = '0;
      ph_d = ~ph_q;
    end
  end

  always_comb begin
    logic seen;
    logic [6:0] seg;
    seen = 1'b0;
    seg = BLANK;
    hex_d = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (dig_q[4*i +: 4] != 4'd0);
      seg = gl[i];
      if (lzc_q && !seen && i != 0)
        seg = BLANK;
      if (ovf_q)
        seg = DASH;
      if (!ld_q || (blink_en && ph_q))
        seg = BLANK;
      hex_d[7*i +: 7] = seg;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      val_q <= '0;
      dm_q <= 1'b0;
      lz_q <= 1'b0;
      ovp_q <= 1'b0;
      cnt_q <= '0;
      bcd_q <= '0;
      dig_q <= '0;
      ovf_q <= 1'b0;
      lzc_q <= 1'b0;
      ld_q <= 1'b0;
      busy_q <= 1'b0;
      bcnt_q <= '0;
      ph_q <= 1'b0;
      hex_q <= '1;
    end else begin
      state_q <= state_d;
      val_q <= val_d;
      dm_q <= dm_d;
      lz_q <= lz_d;
      ovp_q <= ovp_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
      dig_q <= dig_d;
      ovf_q <= ovf_d;
      lzc_q <= lzc_d;
      ld_q <= ld_d;
      busy_q <= busy_d;
      bcnt_q <= bcnt_d;
      ph_q <= ph_d;
      hex_q <= hex_d;
    end
  end

  assign busy = busy_q;
  assign overflow = ovf_q;
  assign HEX = hex_q;

endmodule
